// File: rtl/intt_core.sv
// intt_core: Kyber512 inverse NTT. Seven Gentleman-Sande layers run through a
// single two-cycle butterfly, then every coefficient is scaled by 128^-1 mod Q.
// Coefficients live in 256 lane registers; the shared datapath writes back into them.

module intt_coef_reg #(
    parameter int VEC_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             load_en,
    input  logic [VEC_W-1:0] load_val,
    input  logic             wr_en,
    input  logic [VEC_W-1:0] wr_val,
    output logic [VEC_W-1:0] q
);
    // Bulk load from the input bus wins over a datapath write-back
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)      q <= '0;
        else if (load_en) q <= load_val;
        else if (wr_en)   q <= wr_val;
    end
endmodule

module intt_core #(
    parameter int Q       = 3329,
    parameter int F_SCALE = 3303
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic [3071:0] i_ntt,
    output logic [3071:0] o_poly,
    output logic          o_busy,
    output logic          o_done
);
    localparam int NUM_LANES = 256;
    localparam int VEC_W     = 12;

    localparam logic [12:0]     QW      = 13'(Q);
    localparam logic [24:0]     Q25     = 25'(Q);
    // Barrett constant floor(2^36/Q); products stay below 2^24 so the
    // quotient estimate is off by at most one.
    localparam longint unsigned BAR_M_L = (64'd1 << 36) / Q;
    localparam logic [24:0]     BAR_M   = 25'(BAR_M_L);

    typedef enum logic [1:0] {S_IDLE, S_INTT, S_SCALE, S_DONE} state_t;

    typedef struct packed {
        logic [VEC_W-1:0] h;
        logic [VEC_W-1:0] d;
        logic [VEC_W-1:0] zeta;
    } bf_t;

    // zeta[k] = 17^brv7(k) mod Q, evaluated at elaboration
    function automatic int zeta_calc(input int k);
        int e;
        int r;
        e = 0;
        for (int b = 0; b < 7; b++) e = e | (((k >> b) & 1) << (6 - b));
        r = 1;
        for (int i = 0; i < 128; i++) if (i < e) r = (r * 17) % Q;
        return r;
    endfunction

    state_t state, state_nx;
    logic [2:0] stage;
    logic [6:0] num;
    logic       phase;
    logic [7:0] sidx;
    bf_t        bf_q;

    logic [NUM_LANES-1:0][VEC_W-1:0] coef;
    logic [NUM_LANES-1:0][VEC_W-1:0] wr_val;
    logic [NUM_LANES-1:0]            wr_en;
    logic                            load_en;
    logic [VEC_W-1:0]                zeta_rom [128];

    for (genvar g = 0; g < 128; g++) begin : g_zeta
        localparam int ZV = zeta_calc(g);
        assign zeta_rom[g] = VEC_W'(ZV);
    end

    // Butterfly addressing for the current (stage, num)
    logic [7:0] len, j_idx, p_idx;
    logic [6:0] grp, k_idx;
    assign len   = 8'd1 << (stage + 3'd1);
    assign grp   = num >> (stage + 3'd1);
    assign j_idx = ({1'b0, grp} << ({1'b0, stage} + 4'd2)) | ({1'b0, num} & (len - 8'd1));
    assign p_idx = j_idx + len;
    assign k_idx = 7'((8'd128 >> stage) - 8'd1 - {1'b0, grp});

    // GS add/sub half, each a single conditional correction
    logic [VEC_W-1:0] x, y, h_nx, d_nx;
    logic [12:0]      sum;
    assign x    = coef[j_idx];
    assign y    = coef[p_idx];
    assign sum  = {1'b0, x} + {1'b0, y};
    assign h_nx = (sum >= QW) ? 12'(sum - QW) : sum[11:0];
    assign d_nx = (y >= x) ? (y - x) : 12'({1'b0, y} + QW - {1'b0, x});

    // Shared modular multiplier: butterfly twist in INTT, 128^-1 scaling in SCALE
    logic [VEC_W-1:0] mul_a, mul_b, mul_res;
    logic [23:0]      prod;
    logic [12:0]      q_est;
    logic [24:0]      rem;
    assign mul_a   = (state == S_SCALE) ? coef[sidx] : bf_q.d;
    assign mul_b   = (state == S_SCALE) ? VEC_W'(F_SCALE) : bf_q.zeta;
    assign prod    = 24'(mul_a) * 24'(mul_b);
    assign q_est   = 13'((49'(prod) * 49'(BAR_M)) >> 36);
    assign rem     = 25'(prod) - 25'(q_est) * Q25;
    assign mul_res = 12'((rem >= Q25) ? rem - Q25 : rem);

    assign load_en = (state == S_IDLE) && i_start;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign wr_en[g]  = ((state == S_INTT) && phase && ((j_idx == 8'(g)) || (p_idx == 8'(g))))
                         || ((state == S_SCALE) && (sidx == 8'(g)));
        assign wr_val[g] = ((state == S_INTT) && (j_idx == 8'(g))) ? bf_q.h : mul_res;

        intt_coef_reg #(.VEC_W(VEC_W)) u_lane (
            .i_clk    (i_clk),
            .i_rstn   (i_rstn),
            .load_en  (load_en),
            .load_val (i_ntt[g*VEC_W +: VEC_W]),
            .wr_en    (wr_en[g]),
            .wr_val   (wr_val[g]),
            .q        (coef[g])
        );
    end

    assign o_poly = coef;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        case (state)
            S_IDLE:  if (i_start) state_nx = S_INTT;
            S_INTT: begin
                o_busy = 1'b1;
                if (stage == 3'd6 && num == 7'd127 && phase) state_nx = S_SCALE;
            end
            S_SCALE: begin
                o_busy = 1'b1;
                if (sidx == 8'd255) state_nx = S_DONE;
            end
            S_DONE: begin
                o_done   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Loop counters and the butterfly pipeline register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stage <= '0;
            num   <= '0;
            phase <= 1'b0;
            sidx  <= '0;
            bf_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    stage <= '0;
                    num   <= '0;
                    phase <= 1'b0;
                    sidx  <= '0;
                end
                S_INTT: begin
                    phase <= ~phase;
                    if (!phase) begin
                        bf_q <= '{h: h_nx, d: d_nx, zeta: zeta_rom[k_idx]};
                    end else begin
                        num <= num + 7'd1;
                        if (num == 7'd127) stage <= (stage == 3'd6) ? 3'd0 : stage + 3'd1;
                        sidx <= '0;
                    end
                end
                S_SCALE: sidx <= sidx + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_intt_core.sv
// tb_intt_core: directed + randomized checks of the inverse NTT. Stimulus is the
// forward Kyber NTT of a random polynomial; the expected output is the polynomial.
module tb_intt_core;
    localparam int Q = 3329;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_start;
    logic [3071:0] i_ntt;
    logic [3071:0] o_poly;
    logic          o_busy;
    logic          o_done;

    int errors = 0;
    int checks = 0;
    int zt [128];

    intt_core dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_start (i_start),
        .i_ntt   (i_ntt),
        .o_poly  (o_poly),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_poly(input string tag, input logic [3071:0] obs, input logic [3071:0] exp);
        int bad;
        bad = 0;
        for (int i = 255; i >= 0; i--) if (obs[12*i +: 12] !== exp[12*i +: 12]) bad = i;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: coef[%0d] got %0d, want %0d", tag, bad, obs[12*bad +: 12], exp[12*bad +: 12]);
        end
    endtask

    function automatic int brv7(input int k);
        int r;
        r = 0;
        for (int b = 0; b < 7; b++) if ((k >> b) & 1) r = r | (1 << (6 - b));
        return r;
    endfunction

    function automatic int pow17(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * 17) % Q;
        return r;
    endfunction

    // Forward Kyber NTT (Cooley-Tukey, len 128 down to 2), plain integer arithmetic
    function automatic logic [3071:0] fwd_ntt(input logic [3071:0] a);
        int r [256];
        int k, len, start, j, t, z;
        logic [3071:0] res;
        for (int i = 0; i < 256; i++) r[i] = int'(a[12*i +: 12]);
        k = 1;
        for (len = 128; len >= 2; len = len / 2) begin
            for (start = 0; start < 256; start = j + len) begin
                z = zt[k];
                k++;
                for (j = start; j < start + len; j++) begin
                    t        = (z * r[j+len]) % Q;
                    r[j+len] = (r[j] - t + Q) % Q;
                    r[j]     = (r[j] + t) % Q;
                end
            end
        end
        for (int i = 0; i < 256; i++) res[12*i +: 12] = 12'(r[i]);
        return res;
    endfunction

    function automatic logic [3071:0] rand_poly();
        logic [3071:0] p;
        for (int i = 0; i < 256; i++) p[12*i +: 12] = 12'($urandom_range(0, Q - 1));
        return p;
    endfunction

    // Waits (bounded) for o_done, counting cycles and busy cycles; optional start pulses
    task automatic wait_done(input int pa, input int pb, output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (!o_done && lat < 3000) begin
            i_start = (lat == pa) || (lat == pb);
            busy += int'(o_busy);
            tick;
            lat++;
        end
        i_start = 1'b0;
    endtask

    task automatic do_run(input string tag, input logic [3071:0] din, input logic [3071:0] exp);
        int lat, busy;
        i_ntt   = din;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        wait_done(-1, -1, lat, busy);
        check({tag, "_lat"}, lat, 2048);
        check({tag, "_busy"}, busy, 2048);
        check_poly({tag, "_poly"}, o_poly, exp);
        tick;
        check({tag, "_donepulse"}, int'(o_done), 0);
    endtask

    initial begin
        logic [3071:0] a, b, din, exp;
        int lat, busy, extra, gap;

        for (int k = 0; k < 128; k++) zt[k] = pow17(brv7(k));

        // Reset state
        i_rstn  = 1'b0;
        i_start = 1'b0;
        i_ntt   = '0;
        repeat (3) tick;
        check_poly("reset_poly", o_poly, '0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_done", int'(o_done), 0);
        i_rstn = 1'b1;
        tick;
        check("idle_done", int'(o_done), 0);

        // All-zero input
        do_run("zero", '0, '0);

        // Delta: even NTT coefficients 1 -> c0 = 1
        din = '0;
        for (int i = 0; i < 256; i += 2) din[12*i +: 12] = 12'd1;
        exp = '0;
        exp[11:0] = 12'd1;
        do_run("delta", din, exp);

        // Negated delta: wrap at Q-1
        din = '0;
        for (int i = 0; i < 256; i += 2) din[12*i +: 12] = 12'd3328;
        exp = '0;
        exp[11:0] = 12'd3328;
        do_run("negdelta", din, exp);

        // Random round trips
        for (int n = 0; n < 20; n++) begin
            a = rand_poly();
            do_run($sformatf("rt%0d", n), fwd_ntt(a), a);
        end

        // Start pulses during a run are ignored
        a       = rand_poly();
        i_ntt   = fwd_ntt(a);
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        wait_done(5, 1500, lat, busy);
        check("pulse_lat", lat, 2048);
        check_poly("pulse_poly", o_poly, a);
        extra = 0;
        repeat (20) begin
            tick;
            extra += int'(o_done) + int'(o_busy);
        end
        check("pulse_norestart", extra, 0);

        // Start held high: back-to-back runs, second reloads the new i_ntt
        a       = rand_poly();
        b       = rand_poly();
        i_ntt   = fwd_ntt(a);
        i_start = 1'b1;
        tick;
        lat = 0;
        while (!o_done && lat < 3000) begin
            tick;
            lat++;
        end
        check("hold_lat1", lat, 2048);
        check_poly("hold_poly1", o_poly, a);
        i_ntt = fwd_ntt(b);
        gap   = 0;
        do begin
            tick;
            gap++;
            if (gap == 3) i_start = 1'b0;
        end while (!o_done && gap < 3000);
        i_start = 1'b0;
        check("hold_gap", gap, 2050);
        check_poly("hold_poly2", o_poly, b);
        tick;

        // Reset mid-run aborts to the reset state
        a       = rand_poly();
        i_ntt   = fwd_ntt(a);
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        repeat (1000) tick;
        i_rstn = 1'b0;
        #1;
        check_poly("abort_poly", o_poly, '0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        tick;
        i_rstn = 1'b1;
        extra  = 0;
        repeat (100) begin
            tick;
            extra += int'(o_done) + int'(o_busy);
        end
        check("abort_idle", extra, 0);
        a = rand_poly();
        do_run("fresh", fwd_ntt(a), a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/intt_core.md
Name: intt_core

Overview:
- Inverse NTT engine for the Kyber512 datapath; counterpart to the forward NTT block.
- Accepts a 256-coefficient polynomial in NTT domain on `i_ntt` and runs 7 Gentleman-Sande (GS) butterfly layers through one internal butterfly.
- Applies the final scaling by 128^-1 mod q (3303) and presents the normal-domain polynomial on `o_poly`.
- Sits after the pointwise-multiply stage, feeding compress/encode.

Parameters:
- Q, 3329, Kyber modulus.
- F_SCALE, 3303, 128^-1 mod Q, applied in the SCALE phase.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  reset; asynchronous, active-low.
- i_start  input  1  start request; sampled only in IDLE.
- i_ntt  input  3072  NTT-domain coefficients, canonical [0,Q-1]; coefficient i at bits [12*i+11 : 12*i].
- o_poly  output  3072  result coefficients; same packing; continuously driven from the coefficient registers.
- o_busy  output  1  high in INTT and SCALE.
- o_done  output  1  one-cycle pulse, high in state DONE.

Behaviour:
- Reset:
  - state=IDLE; all 256 coefficient registers=0, so o_poly=0.
  - Counters=0; o_busy=0; o_done=0.
  - Reset asserted mid-operation aborts immediately to these values.
- IDLE:
  - On i_start=1: load all coefficients from i_ntt at that edge; go to INTT; stage=0, num=0, phase=0.
  - While i_start=0: registers hold, so o_poly keeps the last result.
- INTT: stage s=0..6, butterfly num n=0..127, each butterfly takes 2 cycles (phase 0/1). Derived values:
  - len = 1<<(s+1).
  - grp = n>>(s+1).
  - j = (grp<<(s+2)) | (n & (len-1)); partner index j+len.
  - zeta index k = (128>>s) - 1 - grp. Stage 0 uses k=127..64; stage 6 uses only k=1.
- Zeta ROM:
  - zeta[k] = 17^brv7(k) mod Q, 128 entries, normal (non-Montgomery) domain.
  - zeta[0]=1, zeta[1]=1729.
- Phase 0:
  - Read x=c[j], y=c[j+len].
  - Register h=(x+y) mod Q and d=(y-x) mod Q, each one conditional subtract/add.
  - Register zeta[k].
- Phase 1:
  - l = (d*zeta) mod Q, full 24-bit product with exact reduction into [0,Q-1].
  - Write c[j]=h and c[j+len]=l at the edge.
  - Advance num; at num=127, num wraps to 0 and stage increments.
- After stage 6, num 127, phase 1: go to SCALE with num=0.
- No overlap between butterflies, so no read-after-write hazard.
- SCALE:
  - For idx=0..255, one per cycle: c[idx] = (c[idx]*F_SCALE) mod Q.
  - Uses the same modular multiplier as phase 1.
  - After idx=255, go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Latency:
  - Start edge at edge 0: INTT occupies 1792 cycles, SCALE occupies 256 cycles.
  - State=DONE after edge 2048; o_done high from edge 2048 to edge 2049.
- i_start outside IDLE is ignored.
- i_start held high through DONE restarts at the IDLE edge following DONE, reloading from i_ntt.
- o_poly shows intermediate values while o_busy=1; it is valid only from o_done onward until the next start.
- All stored coefficients stay canonical [0,Q-1] at every edge, given canonical inputs.

Test Plan:
- Reset then idle: o_poly=0, o_done=0, o_busy=0; i_start=1 with i_ntt=0 -> o_done after exactly 2048 cycles, o_poly all 0.
- Delta recovery: i_ntt even coefficients=1, odd=0 -> o_poly c0=1, c1..c255=0.
- Negated delta: even coefficients=3328, odd=0 -> c0=3328, others 0; checks wrap at Q-1 and canonical output.
- Random round-trip: 20 random polynomials a; drive NTT(a) from the golden model -> o_poly==a each time; o_busy high for exactly 2048 cycles per run.
- i_start pulsed at cycles 5 and 1500 after start -> ignored, single o_done at 2048, result unchanged; i_start held high -> back-to-back runs, second o_done 2050 cycles after the first.
- i_rstn low at cycle 1000 -> o_poly=0, state IDLE, no o_done; fresh start afterwards completes correctly.
